// File: rtl/accumulate_pipe_pkg.sv
// Shared types and the fold operator for the accumulate_pipe reduction engine.
package accumulate_pkg;

    // Internal width of the fold operator; callers sign-extend into it and
    // truncate the result, so any element width up to FOLD_W works.
    localparam int FOLD_W = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } acc_state_t;

    typedef enum logic [1:0] {
        SUM = 2'd0,
        MAX = 2'd1,
        MIN = 2'd2,
        XOR = 2'd3
    } acc_mode_t;

    // One reduction step. Ties in MAX/MIN keep the accumulator.
    function automatic logic signed [FOLD_W-1:0] fold(
        input acc_mode_t                 op,
        input logic signed [FOLD_W-1:0]  acc,
        input logic signed [FOLD_W-1:0]  d
    );
        logic signed [FOLD_W-1:0] r;
        case (op)
            SUM:     r = acc + d;
            MAX:     r = (d > acc) ? d : acc;
            MIN:     r = (d < acc) ? d : acc;
            default: r = acc ^ d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/accumulate_pipe_ram.sv
// Single-port array storage: registered read, write suppresses the read.
module accum_ram #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 1000,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [0:DEPTH-1];
    logic [DATA_W-1:0] rdata_q;
    logic              in_range;

    assign in_range = (32'(addr_i) < DEPTH);

    // Write or read one word per cycle; addresses past DEPTH write nothing and read zero.
    always_ff @(posedge clk) begin
        if (we_i) begin
            if (in_range) begin
                mem_q[addr_i] <= wdata_i;
            end
        end else begin
            rdata_q <= in_range ? mem_q[addr_i] : '0;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/accumulate_pipe.sv
// Array reduction engine: folds arr[init_i .. end_i-1] into one accumulator,
// optionally writing the running value back. The host shares the RAM port.
//
//  state | meaning
//  IDLE  | waiting for the first start since reset
//  RUN   | issuing reads (and write-backs); frozen while the host owns the RAM
//  DRAIN | folding the last returned element
//  DONE  | result valid, w_enable high; a start is accepted again
module accumulate_pipe
    import accumulate_pkg::*;
#(
    parameter int DATA_W = 64,      // must not exceed FOLD_W
    parameter int DEPTH  = 1000,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r_enable,
    input  logic [ADDR_W-1:0] init_i,
    input  logic [ADDR_W:0]   end_i,
    input  logic [DATA_W-1:0] init_acc,
    input  logic [1:0]        mode,
    input  logic              writeback,
    input  logic              controlArr,
    input  logic              controlArrWEnable_a,
    input  logic [ADDR_W-1:0] controlArrAddr_a,
    input  logic [DATA_W-1:0] controlArrWData_a,
    output logic [DATA_W-1:0] controlArrRData_a,
    output logic              busy,
    output logic              w_enable,
    output logic [DATA_W-1:0] result
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] IDX_ONE = (ADDR_W+1)'(1);

    acc_state_t               state_q, state_d;
    acc_mode_t                mode_q, mode_d;
    logic                     wb_q, wb_d;
    logic                     phase_q, phase_d;     // write-back: 0 read slot, 1 write slot
    logic                     rvalid_q, rvalid_d;   // RAM output holds an engine read this cycle
    logic [ADDR_W:0]          idx_q, idx_d;
    logic [ADDR_W:0]          end_q, end_d;
    logic signed [DATA_W-1:0] acc_q, acc_d;
    logic signed [DATA_W-1:0] result_q, result_d;

    logic [ADDR_W:0]          end_clamp;
    logic                     start, empty, last_item, issue, wb_wr;
    logic signed [DATA_W-1:0] ram_rdata, fold_val, wb_data;
    logic                     ram_we;
    logic [ADDR_W-1:0]        ram_addr;
    logic [DATA_W-1:0]        ram_wdata;

    assign end_clamp = (end_i > DEPTH_L) ? DEPTH_L : end_i;
    assign start     = r_enable && (state_q == IDLE || state_q == DONE);
    assign empty     = ({1'b0, init_i} >= end_clamp);
    assign last_item = ((idx_q + IDX_ONE) == end_q);
    assign fold_val  = DATA_W'(fold(mode_q, FOLD_W'(acc_q), FOLD_W'(ram_rdata)));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: RUN advances only when the host is off the port
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (r_enable) state_d = empty ? DRAIN : RUN;
            RUN:        if (!controlArr && last_item && (!wb_q || phase_q)) state_d = DRAIN;
            DRAIN:      state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    // Outputs: engine issue/write-back, datapath next values and the RAM port mux
    always_comb begin
        issue    = (state_q == RUN) && !controlArr && (!wb_q || !phase_q);
        wb_wr    = (state_q == RUN) && !controlArr && wb_q && phase_q;
        // A fold that landed while frozen is already in acc_q.
        wb_data  = rvalid_q ? fold_val : acc_q;

        mode_d   = mode_q;
        wb_d     = wb_q;
        end_d    = end_q;
        idx_d    = idx_q;
        phase_d  = phase_q;
        acc_d    = acc_q;
        rvalid_d = issue;

        if (start) begin
            mode_d  = acc_mode_t'(mode);
            wb_d    = writeback;
            end_d   = end_clamp;
            idx_d   = {1'b0, init_i};
            phase_d = 1'b0;
            acc_d   = init_acc;
        end else begin
            if (rvalid_q) acc_d = fold_val;
            if (issue && wb_q) phase_d = 1'b1;
            if (wb_wr) phase_d = 1'b0;
            if ((issue && !wb_q) || wb_wr) idx_d = idx_q + IDX_ONE;
        end

        result_d = (state_q == DRAIN) ? acc_d : result_q;

        if (controlArr) begin
            ram_we    = controlArrWEnable_a;
            ram_addr  = controlArrAddr_a;
            ram_wdata = controlArrWData_a;
        end else begin
            ram_we    = wb_wr;
            ram_addr  = idx_q[ADDR_W-1:0];
            ram_wdata = wb_data;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q   <= SUM;
            wb_q     <= 1'b0;
            end_q    <= '0;
            idx_q    <= '0;
            phase_q  <= 1'b0;
            acc_q    <= '0;
            rvalid_q <= 1'b0;
            result_q <= '0;
        end else begin
            mode_q   <= mode_d;
            wb_q     <= wb_d;
            end_q    <= end_d;
            idx_q    <= idx_d;
            phase_q  <= phase_d;
            acc_q    <= acc_d;
            rvalid_q <= rvalid_d;
            result_q <= result_d;
        end
    end

    accum_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    assign controlArrRData_a = ram_rdata;
    assign busy              = (state_q == RUN) || (state_q == DRAIN);
    assign w_enable          = (state_q == DONE);
    assign result            = result_q;

endmodule

// File: tb/tb_accumulate_pipe.sv
// Directed bench for accumulate_pipe: vector tables plus hand-written
// sequences for host bypass, mid-run reset and write-back.
module tb_accumulate_pipe;

    localparam int DATA_W = 64;
    localparam int DEPTH  = 1000;
    localparam int ADDR_W = 10;
    localparam int LAT_LIMIT = 5000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              r_enable = 1'b0;
    logic [ADDR_W-1:0] init_i = '0;
    logic [ADDR_W:0]   end_i = '0;
    logic [DATA_W-1:0] init_acc = '0;
    logic [1:0]        mode = '0;
    logic              writeback = 1'b0;
    logic              controlArr = 1'b0;
    logic              controlArrWEnable_a = 1'b0;
    logic [ADDR_W-1:0] controlArrAddr_a = '0;
    logic [DATA_W-1:0] controlArrWData_a = '0;
    logic [DATA_W-1:0] controlArrRData_a;
    logic              busy;
    logic              w_enable;
    logic [DATA_W-1:0] result;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    accumulate_pipe #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .r_enable            (r_enable),
        .init_i              (init_i),
        .end_i               (end_i),
        .init_acc            (init_acc),
        .mode                (mode),
        .writeback           (writeback),
        .controlArr          (controlArr),
        .controlArrWEnable_a (controlArrWEnable_a),
        .controlArrAddr_a    (controlArrAddr_a),
        .controlArrWData_a   (controlArrWData_a),
        .controlArrRData_a   (controlArrRData_a),
        .busy                (busy),
        .w_enable            (w_enable),
        .result              (result)
    );

    typedef struct {
        logic [ADDR_W-1:0]   init;
        logic [ADDR_W:0]     fin;
        logic signed [63:0]  acc;
        logic [1:0]          op;
        logic signed [63:0]  exp_res;
        int                  exp_lat;   // edges after the start edge until w_enable is seen
    } vec_t;

    vec_t vec_a [9];
    vec_t vec_b [5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic host_write(input int addr, input logic [63:0] data);
        controlArr          = 1'b1;
        controlArrWEnable_a = 1'b1;
        controlArrAddr_a    = ADDR_W'(addr);
        controlArrWData_a   = data;
        tick();
        controlArrWEnable_a = 1'b0;
        controlArr          = 1'b0;
    endtask

    task automatic host_read(input int addr, output logic [63:0] data);
        controlArr          = 1'b1;
        controlArrWEnable_a = 1'b0;
        controlArrAddr_a    = ADDR_W'(addr);
        tick();
        data       = controlArrRData_a;
        controlArr = 1'b0;
    endtask

    task automatic pulse_start(input logic [ADDR_W-1:0] a, input logic [ADDR_W:0] b,
                               input logic [63:0] acc, input logic [1:0] op, input logic wb);
        init_i    = a;
        end_i     = b;
        init_acc  = acc;
        mode      = op;
        writeback = wb;
        r_enable  = 1'b1;
        tick();
        r_enable  = 1'b0;
    endtask

    task automatic wait_done(input int from, output int lat);
        lat = from;
        do begin
            tick();
            lat++;
        end while (!w_enable && lat < LAT_LIMIT);
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int lat;
        pulse_start(v.init, v.fin, v.acc, v.op, 1'b0);
        wait_done(0, lat);
        check({tag, "_lat"}, lat, v.exp_lat);
        check({tag, "_result"}, result, v.exp_res);
    endtask

    initial begin
        int lat;
        logic [63:0] rd;

        // arr[i] = i
        vec_a[0] = '{init: 0,   fin: 1000, acc: 0,    op: 0, exp_res: 499500, exp_lat: 1001};
        vec_a[1] = '{init: 995, fin: 1023, acc: 0,    op: 0, exp_res: 4985,   exp_lat: 6};
        vec_a[2] = '{init: 7,   fin: 7,    acc: 42,   op: 0, exp_res: 42,     exp_lat: 1};
        vec_a[3] = '{init: 20,  fin: 10,   acc: 7,    op: 1, exp_res: 7,      exp_lat: 1};
        vec_a[4] = '{init: 10,  fin: 20,   acc: -100, op: 1, exp_res: 19,     exp_lat: 11};
        vec_a[5] = '{init: 10,  fin: 20,   acc: 100,  op: 2, exp_res: 10,     exp_lat: 11};
        vec_a[6] = '{init: 1,   fin: 4,    acc: 5,    op: 3, exp_res: 5,      exp_lat: 4};
        vec_a[7] = '{init: 999, fin: 1000, acc: 1,    op: 0, exp_res: 1000,   exp_lat: 2};
        vec_a[8] = '{init: 999, fin: 1023, acc: 0,    op: 3, exp_res: 999,    exp_lat: 2};
        // arr[5..7] = {-3,9,9}, arr[900] = 2**63-1, arr[901] = 1
        vec_b[0] = '{init: 5,   fin: 8,    acc: -100, op: 1, exp_res: 9,      exp_lat: 4};
        vec_b[1] = '{init: 5,   fin: 8,    acc: 100,  op: 2, exp_res: -3,     exp_lat: 4};
        vec_b[2] = '{init: 5,   fin: 8,    acc: 0,    op: 3, exp_res: -3,     exp_lat: 4};
        vec_b[3] = '{init: 900, fin: 902,  acc: 0,    op: 0, exp_res: 64'h8000_0000_0000_0000, exp_lat: 3};
        vec_b[4] = '{init: 4,   fin: 9,    acc: 0,    op: 0, exp_res: 27,     exp_lat: 6};

        tick();
        tick();
        rst = 1'b0;
        check("reset_busy", busy, 0);
        check("reset_w_enable", w_enable, 0);
        check("reset_result", result, 0);

        for (int i = 0; i < DEPTH; i++) host_write(i, 64'(i));
        for (int i = 0; i < 9; i++) run_vec($sformatf("vecA%0d", i), vec_a[i]);

        // Host takes the port for 3 cycles mid-run and reads arr[0].
        pulse_start(0, 1000, 0, 0, 1'b0);
        lat = 0;
        repeat (100) begin tick(); lat++; end
        controlArr       = 1'b1;
        controlArrAddr_a = '0;
        tick(); lat++;
        check("bypass_rdata", controlArrRData_a, 0);
        check("bypass_busy", busy, 1);
        tick(); lat++;
        tick(); lat++;
        controlArr = 1'b0;
        wait_done(lat, lat);
        check("bypass_lat", lat, 1004);
        check("bypass_result", result, 499500);

        // Reset at k+20, then a restart with noise on the start inputs while busy.
        pulse_start(0, 1000, 0, 0, 1'b0);
        repeat (19) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_w_enable", w_enable, 0);
        check("midrst_result", result, 0);
        pulse_start(0, 1000, 0, 0, 1'b0);
        lat = 0;
        repeat (3) begin tick(); lat++; end
        init_acc = 64'd12345;
        mode     = 2'd1;
        init_i   = 10'd500;
        end_i    = 11'd501;
        r_enable = 1'b1;
        tick(); lat++;
        r_enable = 1'b0;
        wait_done(lat, lat);
        check("restart_lat", lat, 1001);
        check("restart_result", result, 499500);

        host_write(5, -64'sd3);
        host_write(6, 64'd9);
        host_write(7, 64'd9);
        host_write(900, 64'h7FFF_FFFF_FFFF_FFFF);
        host_write(901, 64'd1);
        for (int i = 0; i < 5; i++) run_vec($sformatf("vecB%0d", i), vec_b[i]);

        // Write-back SUM over {1,2,3,4}.
        for (int i = 0; i < 4; i++) host_write(i, 64'(i + 1));
        pulse_start(0, 4, 0, 0, 1'b1);
        wait_done(0, lat);
        check("wb_lat", lat, 9);
        check("wb_result", result, 10);
        host_read(0, rd); check("wb_arr0", rd, 1);
        host_read(1, rd); check("wb_arr1", rd, 3);
        host_read(2, rd); check("wb_arr2", rd, 6);
        host_read(3, rd); check("wb_arr3", rd, 10);
        host_read(4, rd); check("wb_arr4", rd, 4);

        // Write-back with the host taking the port during the first write slot.
        pulse_start(10, 12, 0, 0, 1'b1);
        lat = 0;
        tick(); lat++;
        controlArr       = 1'b1;
        controlArrAddr_a = 10'd12;
        tick(); lat++;
        check("wbfrz_rdata", controlArrRData_a, 12);
        tick(); lat++;
        controlArr = 1'b0;
        wait_done(lat, lat);
        check("wbfrz_lat", lat, 7);
        check("wbfrz_result", result, 21);
        host_read(10, rd); check("wbfrz_arr10", rd, 10);
        host_read(11, rd); check("wbfrz_arr11", rd, 21);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
